// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES-128 core controller
package aes_pkg;

    typedef enum logic [2:0] {
        CTRL_IDLE = 3'd0,
        KEY_START = 3'd1,
        KEY_WAIT  = 3'd2,
        ENC_START = 3'd3,
        ENC_WAIT  = 3'd4
    } ctrl_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NOKEY   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_BUSY    = 2'b11;

    localparam int AES_128_NUM_ROUNDS = 10;

endpackage

// File: rtl/aes_core_ctrl_if.sv
// rtl/aes_core_ctrl_if.sv - controller to key-expansion / encipher / S-box bus
interface aes_core_ctrl_if;

    logic        key_init;
    logic        key_ready;
    logic [31:0] key_sboxw;
    logic        enc_next;
    logic        enc_ready;
    logic [31:0] enc_sboxw;
    logic [31:0] sboxw;

    modport master (
        output key_init, enc_next, sboxw,
        input  key_ready, key_sboxw, enc_ready, enc_sboxw
    );

    modport slave (
        input  key_init, enc_next, sboxw,
        output key_ready, key_sboxw, enc_ready, enc_sboxw
    );

endinterface

// File: rtl/aes_ctrl_watchdog.sv
// rtl/aes_ctrl_watchdog.sv - saturating wait-state watchdog counter
module aes_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic cnt_zero,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero count marks the first wait cycle, where sub-block ready is still stale.
    assign cnt_zero = (cnt_q == '0);
    assign expired  = (cnt_q == LAST);

endmodule

// File: rtl/aes_core_ctrl.sv
// rtl/aes_core_ctrl.sv - AES-128 core sequencer: key expansion, encipher, shared S-box
module aes_core_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  next,
    output logic                  ready,
    output logic                  key_valid,
    output logic                  result_valid,
    output logic                  err,
    output logic [1:0]            err_code,
    aes_core_ctrl_if.master       bus
);

    ctrl_state_e state_q, state_d;
    logic        key_valid_q, key_valid_d;
    logic        result_valid_q, result_valid_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        key_init_q, key_init_d;
    logic        enc_next_q, enc_next_d;
    logic        wd_zero, wd_expired;
    logic        in_start, in_wait, in_key_phase, busy;

    assign in_start     = (state_q == KEY_START) || (state_q == ENC_START);
    assign in_wait      = (state_q == KEY_WAIT)  || (state_q == ENC_WAIT);
    assign in_key_phase = (state_q == KEY_START) || (state_q == KEY_WAIT);
    assign busy         = in_start || in_wait;

    aes_ctrl_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (in_start),
        .enable   (in_wait),
        .cnt_zero (wd_zero),
        .expired  (wd_expired)
    );

    always_comb begin
        state_d        = state_q;
        key_valid_d    = key_valid_q;
        result_valid_d = 1'b0;
        err_d          = 1'b0;
        err_code_d     = err_code_q;
        case (state_q)
            CTRL_IDLE: begin
                if (init) begin
                    state_d     = KEY_START;
                    key_valid_d = 1'b0;
                end else if (next) begin
                    if (key_valid_q) begin
                        state_d = ENC_START;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NOKEY;
                    end
                end
            end
            KEY_START: state_d = KEY_WAIT;
            KEY_WAIT: begin
                if (!wd_zero && bus.key_ready) begin
                    key_valid_d = 1'b1;
                    state_d     = CTRL_IDLE;
                end else if (wd_expired) begin
                    err_d       = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    key_valid_d = 1'b0;
                    state_d     = CTRL_IDLE;
                end
            end
            ENC_START: state_d = ENC_WAIT;
            ENC_WAIT: begin
                if (!wd_zero && bus.enc_ready) begin
                    result_valid_d = 1'b1;
                    state_d        = CTRL_IDLE;
                end else if (wd_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = CTRL_IDLE;
                end
            end
            default: state_d = CTRL_IDLE;
        endcase
        // A command while busy is reported but ignored; its code wins over a same-cycle timeout.
        if (busy && (init || next)) begin
            err_d      = 1'b1;
            err_code_d = ERR_BUSY;
        end
        key_init_d = (state_d == KEY_START);
        enc_next_d = (state_d == ENC_START);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= CTRL_IDLE;
            key_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
            key_init_q     <= 1'b0;
            enc_next_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_valid_q    <= key_valid_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            key_init_q     <= key_init_d;
            enc_next_q     <= enc_next_d;
        end
    end

    assign ready        = (state_q == CTRL_IDLE);
    assign key_valid    = key_valid_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign bus.key_init = key_init_q;
    assign bus.enc_next = enc_next_q;
    assign bus.sboxw    = in_key_phase ? bus.key_sboxw : bus.enc_sboxw;

endmodule

// File: tb/tb_aes_core_ctrl.sv
// tb/tb_aes_core_ctrl.sv - self-checking bench for aes_core_ctrl
module tb_aes_core_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic       next = 1'b0;
    logic       ready, key_valid, result_valid, err;
    logic [1:0] err_code;

    aes_core_ctrl_if bus ();

    aes_core_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .next         (next),
        .ready        (ready),
        .key_valid    (key_valid),
        .result_valid (result_valid),
        .err          (err),
        .err_code     (err_code),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sub-block responders: ready stays stale for one cycle after the start pulse, then drops.
    int  kcnt = 0;
    int  ecnt = 0;
    bit  key_never = 1'b0;
    initial begin
        bus.key_ready = 1'b1;
        bus.enc_ready = 1'b1;
        bus.key_sboxw = 32'h01234567;
        bus.enc_sboxw = 32'hA5A5A5A5;
        forever begin
            @(posedge clk);
            if (reset) kcnt = 0; else if (bus.key_init) kcnt = 1; else if (kcnt > 0) kcnt++;
            if (reset) ecnt = 0; else if (bus.enc_next) ecnt = 1; else if (ecnt > 0) ecnt++;
            #1;
            if (kcnt >= 15 && !key_never) kcnt = 0;
            if (ecnt >= 14) ecnt = 0;
            bus.key_ready = (kcnt < 2);
            bus.enc_ready = (ecnt < 2);
        end
    end

    // Reference model: an operation (0 none, 1 key, 2 enc) and its age in cycles since acceptance.
    int         m_op = 0;
    int         m_age = 0;
    bit         m_kv = 1'b0;
    logic [1:0] m_code = 2'b00;
    bit         m_res = 1'b0, m_err = 1'b0, m_kinit = 1'b0, m_enext = 1'b0, m_live = 1'b0;
    bit         m_done, m_sr;
    int         m_w;
    always @(posedge clk) begin
        m_res  = 1'b0;
        m_err  = 1'b0;
        m_done = 1'b0;
        if (reset) begin
            m_op = 0; m_age = 0; m_kv = 1'b0; m_code = 2'b00; m_live = 1'b1;
        end else if (m_op == 0) begin
            if (init) begin
                m_op = 1; m_age = 1; m_kv = 1'b0;
            end else if (next && m_kv) begin
                m_op = 2; m_age = 1;
            end else if (next) begin
                m_err = 1'b1; m_code = 2'b01;
            end
        end else begin
            if (m_age >= 2) begin
                m_w  = m_age - 2;
                m_sr = (m_op == 1) ? bus.key_ready : bus.enc_ready;
                if (m_w >= 1 && m_sr) begin
                    m_done = 1'b1;
                    if (m_op == 1) m_kv = 1'b1; else m_res = 1'b1;
                end else if (m_w == TO - 1) begin
                    m_done = 1'b1; m_err = 1'b1; m_code = 2'b10;
                    if (m_op == 1) m_kv = 1'b0;
                end
            end
            if (init || next) begin
                m_err = 1'b1; m_code = 2'b11;
            end
            if (m_done) begin
                m_op = 0; m_age = 0;
            end else begin
                m_age++;
            end
        end
        m_kinit = (m_op == 1) && (m_age == 1);
        m_enext = (m_op == 2) && (m_age == 1);
    end

    int n_kinit = 0, n_enext = 0, n_res = 0, n_err = 0;
    always @(negedge clk) begin
        if (m_live) begin
            chk("ready", ready, m_op == 0);
            chk("key_valid", key_valid, m_kv);
            chk("result_valid", result_valid, m_res);
            chk("err", err, m_err);
            chk("err_code", err_code, m_code);
            chk("key_init", bus.key_init, m_kinit);
            chk("enc_next", bus.enc_next, m_enext);
            chk("sboxw", bus.sboxw, (m_op == 1) ? bus.key_sboxw : bus.enc_sboxw);
        end
        n_kinit += bus.key_init;
        n_enext += bus.enc_next;
        n_res   += result_valid;
        n_err   += err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: sig = bus.key_init;
            1: sig = key_valid;
            2: sig = bus.enc_next;
            3: sig = result_valid;
            4: sig = err;
            default: sig = 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(which) && n < limit);
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic pulse_next();
        next = 1'b1;
        tick();
        next = 1'b0;
    endtask

    int n1, n2, s_kinit, s_enext, s_res, s_err;

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_err_code", err_code, 2'b00);
        tick();

        // Key expansion with a well-behaved key block.
        pulse_init();
        wait_sig(0, 5, n1);
        chk("init_to_key_init", n1, 1);
        wait_sig(1, 40, n2);
        chk("init_to_key_valid", n1 + n2, 17);
        chk("key_done_ready", ready, 1'b1);

        // One block encryption.
        tick();
        s_enext = n_enext; s_res = n_res;
        pulse_next();
        wait_sig(2, 5, n1);
        chk("next_to_enc_next", n1, 1);
        wait_sig(3, 40, n2);
        chk("next_to_result", n1 + n2, 16);
        chk("enc_sboxw", bus.sboxw, 32'hA5A5A5A5);
        tick(); tick();
        chk("enc_next_count", n_enext - s_enext, 1);
        chk("result_count", n_res - s_res, 1);

        // next without a key.
        do_reset();
        s_enext = n_enext;
        pulse_next();
        wait_sig(4, 5, n1);
        chk("nokey_err_latency", n1, 1);
        chk("nokey_err_code", err_code, 2'b01);
        chk("nokey_ready", ready, 1'b1);
        tick(); tick();
        chk("nokey_enc_next_count", n_enext - s_enext, 0);

        // Key block that never becomes ready.
        key_never = 1'b1;
        do_reset();
        pulse_init();
        wait_sig(4, 40, n1);
        chk("timeout_latency", n1, 18);
        chk("timeout_err_code", err_code, 2'b10);
        chk("timeout_key_valid", key_valid, 1'b0);
        chk("timeout_ready", ready, 1'b1);
        key_never = 1'b0;
        do_reset();

        // Command during key wait, then init and next together.
        pulse_init();
        wait_sig(0, 5, n1);
        repeat (4) @(negedge clk);
        tick();
        pulse_next();
        @(negedge clk);
        chk("busy_err", err, 1'b1);
        chk("busy_err_code", err_code, 2'b11);
        chk("busy_key_sboxw", bus.sboxw, 32'h01234567);
        chk("busy_ready", ready, 1'b0);
        wait_sig(1, 40, n2);
        chk("busy_key_valid", key_valid, 1'b1);
        tick();
        s_kinit = n_kinit; s_enext = n_enext; s_err = n_err;
        init = 1'b1;
        next = 1'b1;
        tick();
        init = 1'b0;
        next = 1'b0;
        wait_sig(0, 5, n1);
        chk("both_key_init", n1, 1);
        wait_sig(1, 40, n2);
        tick(); tick();
        chk("both_kinit_count", n_kinit - s_kinit, 1);
        chk("both_enext_count", n_enext - s_enext, 0);
        chk("both_err_count", n_err - s_err, 0);

        // Reset in the middle of an encryption.
        pulse_next();
        wait_sig(2, 5, n1);
        repeat (4) @(negedge clk);
        tick();
        do_reset();
        @(negedge clk);
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_key_valid", key_valid, 1'b0);
        chk("mid_rst_pulses", {result_valid, err, bus.key_init, bus.enc_next}, 4'b0000);
        tick();
        pulse_next();
        wait_sig(4, 5, n1);
        chk("post_rst_err", n1, 1);
        chk("post_rst_err_code", err_code, 2'b01);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/aes_core_ctrl.md
Name: aes_core_ctrl

Overview:
- Top-level sequencer for the AES-128 core. Accepts user init/next commands, drives the round-key expansion block (key_init pulse, waits for key_ready), then drives the encipher datapath (enc_next pulse, waits for enc_ready).
- Time-shares the single 32-bit S-box word port between key expansion and the encipher datapath.
- Tracks key validity, enforces a watchdog on both sub-operations and reports protocol errors.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in a WAIT state before the watchdog fires; legal range 16..255.
- CNT_W, 8: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- init  in  1  request key expansion (level sampled per cycle)
- next  in  1  request one block encryption
- ready  out  1  controller idle and able to accept a command
- key_valid  out  1  round keys valid for current key
- result_valid  out  1  one-cycle pulse: encipher result available
- err  out  1  one-cycle error pulse
- err_code  out  2  01 next without valid key, 10 watchdog timeout, 11 command while busy; held until next err
- key_init  out  1  one-cycle pulse to key-expansion init
- key_ready  in  1  key-expansion ready
- key_sboxw  in  32  S-box request word from key expansion
- enc_next  out  1  one-cycle pulse to encipher start
- enc_ready  in  1  encipher ready
- enc_sboxw  in  32  S-box request word from encipher
- sboxw  out  32  word to shared S-box; result returns directly to both requesters

Behaviour:
- Reset (sync, active-high, overrides all): state IDLE, ready=1, key_valid=0, result_valid=0, err=0, err_code=00, key_init=0, enc_next=0, watchdog=0. Sub-blocks have their own reset; a mid-operation reset simply abandons the operation.

States:
- IDLE: ready=1.
  - init=1 → KEY_START, key_valid<=0.
  - Else next=1 with key_valid=1 → ENC_START.
  - Else next=1 with key_valid=0 → err pulse, err_code=01, stay IDLE.
  - init and next together: init wins; next is dropped silently.
- KEY_START: key_init=1 for exactly this cycle; watchdog<=0 → KEY_WAIT.
- KEY_WAIT: the first cycle is skipped for the ready check, because key_ready falls one cycle after the init pulse.
  - From the second cycle on: key_ready=1 → key_valid<=1, IDLE.
  - watchdog reaches TIMEOUT_CYCLES-1 without ready → err pulse, err_code=10, key_valid=0, IDLE.
- ENC_START: enc_next=1 for one cycle, watchdog<=0 → ENC_WAIT.
- ENC_WAIT: same one-cycle skip.
  - enc_ready=1 → result_valid pulse next cycle, IDLE.
  - Timeout → err pulse, err_code=10, IDLE. key_valid is unchanged.
- ready=0 in all states except IDLE.
- init or next asserted in any non-IDLE state → err pulse, code 11; request ignored and current operation continues. This check takes priority over a same-cycle timeout report: timeout is still handled, and the later err overwrites the code.
- Watchdog increments in WAIT states and saturates; it is cleared in START states.
- S-box mux: sboxw=key_sboxw in KEY_START/KEY_WAIT, else enc_sboxw. Combinational, zero latency.
- Outputs result_valid, err, key_init and enc_next are registered (state-decoded flops). No output glitches.
- Latency: init to key_init is 1 cycle. With the 11-generate-cycle key expansion, init to key_valid is approximately 15 cycles.
- Unused state encodings → IDLE.

Decomposition:
- Shared package aes_pkg:
  - state enum CTRL_IDLE/KEY_START/KEY_WAIT/ENC_START/ENC_WAIT;
  - err_code constants ERR_NOKEY=2'b01, ERR_TIMEOUT=2'b10, ERR_BUSY=2'b11;
  - AES_128_NUM_ROUNDS=10.
- Optional sub-module aes_ctrl_watchdog (counter, clear, enable, saturating expiry flag). Everything else stays flat.

Test Plan:
- Reset, then init pulse with a model key block (ready falls at +2, rises 13 cycles later) → key_init at cycle 1, key_valid=1 on the cycle after key_ready, ready=1.
- next with key_valid=1, model encipher ready after 12 cycles → enc_next one pulse, result_valid one pulse, sboxw follows enc_sboxw (0xA5A5A5A5) throughout.
- next after reset, no key → err pulse, err_code=01, no enc_next, state stays IDLE.
- init, key model never raises ready, TIMEOUT_CYCLES=16 → err with err_code=10 after 16 WAIT cycles, key_valid=0, ready=1.
- During KEY_WAIT, assert next → err_code=11, and key_sboxw=0x01234567 still appears on sboxw. Then init and next together in IDLE → only key_init is issued.
- Assert reset mid ENC_WAIT → next cycle: IDLE, key_valid=0, all pulses low; a subsequent next gives err_code=01.
